f_le_arbiter: RTL and testbench
===============================

// Module: f_le_arbiter
// PURPOSE
//  Shares one combinational f_less_or_equal comparator between NREQ requesters,
//  for example several sort_floats FSM instances.
//  - Round-robin grant with optional lock, so a requester keeps the comparator for a
//    multi-compare sequence.
//  - Hold-time watchdog.
//  - Routes operands to the comparator and returns the result to the owning requester.
// PARAMETERS
//  FLEN      64  float width in bits
//  NREQ      4   number of requesters, 2..8
//  MAX_HOLD  8   max consecutive granted cycles for one owner before forced release, >=1
// PORTS
//  clk        in   1          clock
//  rst        in   1          synchronous reset, active-low
//  req        in   NREQ       per-requester request
//  lock       in   NREQ       per-requester keep-grant hint; ignored unless req is also high
//  op_a       in   NREQ*FLEN  per-requester operand a; requester i at [i*FLEN +: FLEN]
//  op_b       in   NREQ*FLEN  per-requester operand b; same packing
//  gnt        out  NREQ       registered one-hot grant; all-zero when idle
//  res_valid  out  1          owner's compare result valid this cycle
//  res        out  1          f_le_res passthrough (a <= b)
//  res_err    out  1          f_le_err passthrough
//  timeout    out  1          1-cycle pulse when the watchdog forced a release
//  f_le_a     out  FLEN       shared comparator operand a
//  f_le_b     out  FLEN       shared comparator operand b
//  f_le_res   in   1          comparator result
//  f_le_err   in   1          comparator error (NaN/Inf operand)
// BEHAVIOUR
//  - Reset (rst==0 at posedge): gnt=0, owner=none, rr_ptr=0, hold_cnt=0, timeout=0, mask=0.
//  - States:
//    - IDLE: gnt==0.
//    - OWNED: gnt one-hot; owner index held in a register.
//  - Comparator path is combinational from gnt:
//    - f_le_a/f_le_b = owner's op_a/op_b; 0 in IDLE.
//    - res_valid = OWNED & req[owner].
//    - res/res_err = f_le_res/f_le_err when res_valid, else 0.
//  - Arbitration, evaluated every cycle, result visible on gnt the next cycle:
//    - Keep: stay with owner if OWNED & req[owner] & lock[owner] & hold_cnt<MAX_HOLD-1.
//      Then hold_cnt increments.
//    - Otherwise grant the first req[i] & ~mask[i] scanning rr_ptr, rr_ptr+1, ... mod NREQ.
//      - On a new grant: hold_cnt=0 and rr_ptr = winner+1 mod NREQ.
//      - The previous owner ranks last, and wins again only if no other request exists.
//    - No eligible request -> IDLE; rr_ptr unchanged.
//    - Request-to-grant latency is 1 cycle: req high at edge N gives gnt high after N+1.
//    - The requester owns the comparator for every cycle its gnt bit is high.
//  - Unlocked use:
//    - Owner with lock=0 gets exactly one compare cycle.
//    - With other requests pending, ownership hands over with no idle cycle.
//    - A sole requester holding req gets back-to-back grants.
//  - Watchdog:
//    - Triggers when OWNED & lock[owner] & req[owner] & hold_cnt==MAX_HOLD-1.
//    - Forced re-arbitration; the owner's mask bit is set for exactly one arbitration.
//    - timeout pulses on the cycle the new gnt appears.
//  - Owner drops req mid-grant: re-arbitrate that cycle; res_valid=0 for that cycle.
//  - gnt is never multi-hot and never points at a requester whose req was low at the
//    previous edge.
//  - Reset mid-sequence wins over everything: next cycle is IDLE; no result is returned.
// CONFIGURATION
//  F_LE_ARB_STATS_EN
//  - Defined: adds output err_cnt [NREQ*8], one 8-bit saturating counter per requester.
//    - Counter i increments on every cycle with res_valid & res_err & owner==i.
//    - Counters reset to 0 and saturate at 255.
//  - Undefined: port and counters are absent; all other behaviour is identical.
// TESTING
//  1. Reset hold, all req=0 -> gnt=0, f_le_a=f_le_b=0, res_valid=0, timeout=0.
//  2. req=4'b0001, lock=0, op_a=1.0, op_b=2.0
//     -> gnt=0001 on the next cycle, res_valid=1, res=1, res_err=0.
//  3. req=4'b1111 held, lock=0, 8 cycles
//     -> gnt sequence 0001,0010,0100,1000,0001,... with no gap.
//  4. req[2]=1, lock[2]=1 held, req[0]=1, MAX_HOLD=8
//     -> gnt=0100 for 8 cycles, then gnt=0001 with timeout=1 for 1 cycle.
//  5. Owner op_a=NaN
//     -> res_err=1; with F_LE_ARB_STATS_EN, err_cnt[owner] increments by 1 each cycle.
//  6. rst=0 asserted while gnt=0010, lock=1 -> gnt=0, hold_cnt=0; after release, grant
//     scanning restarts from requester 0.

Source files
------------

// File: rtl/f_le_arbiter.sv
// Round-robin arbiter sharing one f_less_or_equal comparator between NREQ requesters.
// Optional macro F_LE_ARB_STATS_EN adds per-requester saturating error counters (err_cnt).
module f_le_arbiter #(
    parameter int FLEN     = 64,
    parameter int NREQ     = 4,
    parameter int MAX_HOLD = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ-1:0]      lock,
    input  logic [NREQ*FLEN-1:0] op_a,
    input  logic [NREQ*FLEN-1:0] op_b,
    output logic [NREQ-1:0]      gnt,
    output logic                 res_valid,
    output logic                 res,
    output logic                 res_err,
    output logic                 timeout,
`ifdef F_LE_ARB_STATS_EN
    output logic [NREQ*8-1:0]    err_cnt,
`endif
    output logic [FLEN-1:0]      f_le_a,
    output logic [FLEN-1:0]      f_le_b,
    input  logic                 f_le_res,
    input  logic                 f_le_err
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int HW = $clog2(MAX_HOLD + 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

    typedef enum logic {IDLE, OWNED} state_e;

    state_e            state_q, state_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic [IW-1:0]     owner_q, owner_d;
    logic [IW-1:0]     rr_q, rr_d;
    logic [HW-1:0]     hold_q, hold_d;
    logic              timeout_q, timeout_d;

    logic              resValid;
    logic              keep;
    logic              wdFire;
    logic [NREQ-1:0]   mask;
    logic [NREQ-1:0]   eligible;
    logic              found;
    logic [IW-1:0]     winner;
    int                idx;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            owner_q   <= '0;
            rr_q      <= '0;
            hold_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            owner_q   <= owner_d;
            rr_q      <= rr_d;
            hold_q    <= hold_d;
            timeout_q <= timeout_d;
        end
    end

    // The watchdog mask only lives for the forced arbitration, so it is derived, not stored.
    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        owner_d   = owner_q;
        rr_d      = rr_q;
        hold_d    = hold_q;
        found     = 1'b0;
        winner    = '0;
        idx       = 0;
        mask      = '0;

        resValid  = (state_q == OWNED) && req[owner_q];
        keep      = resValid && lock[owner_q] && (hold_q < HOLD_LAST);
        wdFire    = resValid && lock[owner_q] && (hold_q == HOLD_LAST);
        timeout_d = wdFire;
        if (wdFire) mask[owner_q] = 1'b1;
        eligible  = req & ~mask;

        // Scan downward so the candidate closest to rr_q is the last (winning) assignment.
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = (int'(rr_q) + k) % NREQ;
            if (eligible[idx]) begin
                found  = 1'b1;
                winner = IW'(idx);
            end
        end

        if (keep) begin
            hold_d = hold_q + HW'(1);
        end else if (found) begin
            state_d        = OWNED;
            gnt_d          = '0;
            gnt_d[winner]  = 1'b1;
            owner_d        = winner;
            hold_d         = '0;
            rr_d           = (winner == IW'(NREQ - 1)) ? '0 : winner + IW'(1);
        end else begin
            state_d = IDLE;
            gnt_d   = '0;
            hold_d  = '0;
        end
    end

    assign gnt       = gnt_q;
    assign timeout   = timeout_q;
    assign res_valid = resValid;
    assign res       = resValid & f_le_res;
    assign res_err   = resValid & f_le_err;
    assign f_le_a    = (state_q == OWNED) ? op_a[int'(owner_q)*FLEN +: FLEN] : '0;
    assign f_le_b    = (state_q == OWNED) ? op_b[int'(owner_q)*FLEN +: FLEN] : '0;

`ifdef F_LE_ARB_STATS_EN
    for (genvar i = 0; i < NREQ; i++) begin : g_errCnt
        logic [7:0] cnt_q;
        always_ff @(posedge clk) begin
            if (!rst) begin
                cnt_q <= '0;
            end else if (resValid && f_le_err && (owner_q == IW'(i)) && (cnt_q != 8'hFF)) begin
                cnt_q <= cnt_q + 8'd1;
            end
        end
        assign err_cnt[i*8 +: 8] = cnt_q;
    end
`endif

endmodule

// File: tb/tb_f_le_arbiter.sv
// Self-checking bench for f_le_arbiter: directed scenarios then random traffic against a behavioural model.
// Honours F_LE_ARB_STATS_EN the same way as the design.
module tb_f_le_arbiter;

    localparam int FLEN     = 64;
    localparam int NREQ     = 4;
    localparam int MAX_HOLD = 8;
    localparam logic [63:0] NAN_BITS = 64'h7FF8_0000_0000_0000;
    localparam logic [63:0] INF_BITS = 64'h7FF0_0000_0000_0000;

    logic                 clk;
    logic                 rst;
    logic [NREQ-1:0]      req;
    logic [NREQ-1:0]      lock;
    logic [NREQ*FLEN-1:0] opABus;
    logic [NREQ*FLEN-1:0] opBBus;
    logic [NREQ-1:0]      gnt;
    logic                 resValid;
    logic                 res;
    logic                 resErr;
    logic                 timeout;
    logic [FLEN-1:0]      fLeA;
    logic [FLEN-1:0]      fLeB;
    logic                 fLeRes;
    logic                 fLeErr;
`ifdef F_LE_ARB_STATS_EN
    logic [NREQ*8-1:0]    errCnt;
`endif

    logic [FLEN-1:0] opA [NREQ];
    logic [FLEN-1:0] opB [NREQ];

    int checks = 0;
    int errors = 0;

    int mOwner;
    int mPtr;
    int mHold;
    logic mTimeout;
    int mCnt [NREQ];

    f_le_arbiter #(.FLEN(FLEN), .NREQ(NREQ), .MAX_HOLD(MAX_HOLD)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .lock      (lock),
        .op_a      (opABus),
        .op_b      (opBBus),
        .gnt       (gnt),
        .res_valid (resValid),
        .res       (res),
        .res_err   (resErr),
        .timeout   (timeout),
`ifdef F_LE_ARB_STATS_EN
        .err_cnt   (errCnt),
`endif
        .f_le_a    (fLeA),
        .f_le_b    (fLeB),
        .f_le_res  (fLeRes),
        .f_le_err  (fLeErr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic isSpecial(input logic [63:0] x);
        return x[62:52] == 11'h7FF;
    endfunction

    function automatic logic cmpErr(input logic [63:0] a, input logic [63:0] b);
        return isSpecial(a) || isSpecial(b);
    endfunction

    function automatic logic cmpLe(input logic [63:0] a, input logic [63:0] b);
        if (cmpErr(a, b)) return 1'b0;
        return $bitstoreal(a) <= $bitstoreal(b);
    endfunction

    always_comb begin
        fLeRes = cmpLe(fLeA, fLeB);
        fLeErr = cmpErr(fLeA, fLeB);
    end

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            opABus[i*FLEN +: FLEN] = opA[i];
            opBBus[i*FLEN +: FLEN] = opB[i];
        end
    end

    function automatic logic [63:0] randOperand();
        int pick;
        pick = int'($urandom_range(0, 11));
        if (pick == 0) return NAN_BITS;
        if (pick == 1) return INF_BITS;
        return $realtobits(real'(int'($urandom_range(0, 40))) - 20.0);
    endfunction

    task automatic randomizeOperands();
        for (int i = 0; i < NREQ; i++) begin
            opA[i] = randOperand();
            opB[i] = randOperand();
        end
    endtask

    // Reference: owner keeps the comparator while locked and under the hold limit;
    // otherwise the first requester at or after the pointer wins, the expired owner excluded once.
    task automatic updateModel();
        logic ownerActive;
        logic fire;
        int win;
        int cand;
        if (!rst) begin
            mOwner = -1;
            mPtr = 0;
            mHold = 0;
            mTimeout = 1'b0;
            for (int i = 0; i < NREQ; i++) mCnt[i] = 0;
            return;
        end
        ownerActive = (mOwner >= 0) && req[mOwner];
        if (ownerActive && cmpErr(opA[mOwner], opB[mOwner]) && mCnt[mOwner] < 255)
            mCnt[mOwner] = mCnt[mOwner] + 1;
        fire = ownerActive && lock[mOwner] && (mHold == MAX_HOLD - 1);
        mTimeout = fire;
        if (ownerActive && lock[mOwner] && (mHold < MAX_HOLD - 1)) begin
            mHold = mHold + 1;
        end else begin
            win = -1;
            for (int k = 0; k < NREQ && win < 0; k++) begin
                cand = (mPtr + k) % NREQ;
                if (req[cand] && !(fire && cand == mOwner)) win = cand;
            end
            mHold = 0;
            mOwner = win;
            if (win >= 0) mPtr = (win + 1) % NREQ;
        end
    endtask

    task automatic checkOutput();
        logic [NREQ-1:0] expGnt;
        logic expValid;
        logic [63:0] expA;
        logic [63:0] expB;
        expGnt = '0;
        expA = '0;
        expB = '0;
        expValid = 1'b0;
        if (mOwner >= 0) begin
            expGnt[mOwner] = 1'b1;
            expA = opA[mOwner];
            expB = opB[mOwner];
            expValid = req[mOwner];
        end
        checks += 7;
        assert (gnt === expGnt) else begin
            errors++;
            $error("[TB] FAIL gnt observed=%b expected=%b", gnt, expGnt);
        end
        assert (timeout === mTimeout) else begin
            errors++;
            $error("[TB] FAIL timeout observed=%b expected=%b", timeout, mTimeout);
        end
        assert (resValid === expValid) else begin
            errors++;
            $error("[TB] FAIL res_valid observed=%b expected=%b", resValid, expValid);
        end
        assert (res === (expValid & cmpLe(expA, expB))) else begin
            errors++;
            $error("[TB] FAIL res observed=%b expected=%b", res, expValid & cmpLe(expA, expB));
        end
        assert (resErr === (expValid & cmpErr(expA, expB))) else begin
            errors++;
            $error("[TB] FAIL res_err observed=%b expected=%b", resErr, expValid & cmpErr(expA, expB));
        end
        assert (fLeA === expA) else begin
            errors++;
            $error("[TB] FAIL f_le_a observed=%h expected=%h", fLeA, expA);
        end
        assert (fLeB === expB) else begin
            errors++;
            $error("[TB] FAIL f_le_b observed=%h expected=%h", fLeB, expB);
        end
`ifdef F_LE_ARB_STATS_EN
        for (int i = 0; i < NREQ; i++) begin
            checks++;
            assert (int'(errCnt[i*8 +: 8]) === mCnt[i]) else begin
                errors++;
                $error("[TB] FAIL err_cnt[%0d] observed=%0d expected=%0d", i, errCnt[i*8 +: 8], mCnt[i]);
            end
        end
`endif
    endtask

    // One cycle: drive at the falling edge, check just after, then let the edge commit state.
    task automatic applyStimulus(input logic r, input logic [NREQ-1:0] rq, input logic [NREQ-1:0] lk);
        rst = r;
        req = rq;
        lock = lk;
        #1;
        checkOutput();
        @(posedge clk);
        updateModel();
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b0;
        req = '0;
        lock = '0;
        for (int i = 0; i < NREQ; i++) begin
            opA[i] = '0;
            opB[i] = '0;
        end
        @(posedge clk);
        @(posedge clk);
        updateModel();
        @(negedge clk);

        $display("[TB] reset hold, idle");
        applyStimulus(1'b0, 4'b0000, 4'b0000);
        applyStimulus(1'b0, 4'b0000, 4'b0000);

        $display("[TB] single requester compare 1.0 <= 2.0");
        opA[0] = $realtobits(1.0);
        opB[0] = $realtobits(2.0);
        applyStimulus(1'b1, 4'b0001, 4'b0000);
        applyStimulus(1'b1, 4'b0001, 4'b0000);
        applyStimulus(1'b1, 4'b0000, 4'b0000);

        $display("[TB] four unlocked requesters rotate");
        for (int i = 0; i < NREQ; i++) begin
            opA[i] = $realtobits(real'(i));
            opB[i] = $realtobits(1.5);
        end
        for (int c = 0; c < 9; c++) applyStimulus(1'b1, 4'b1111, 4'b0000);

        $display("[TB] locked owner hits watchdog");
        applyStimulus(1'b1, 4'b0000, 4'b0000);
        applyStimulus(1'b1, 4'b0100, 4'b0100);
        for (int c = 0; c < 10; c++) applyStimulus(1'b1, 4'b0101, 4'b0100);

        $display("[TB] NaN operand reports error");
        applyStimulus(1'b1, 4'b0000, 4'b0000);
        opA[1] = NAN_BITS;
        for (int c = 0; c < 5; c++) applyStimulus(1'b1, 4'b0010, 4'b0010);

        $display("[TB] reset during locked ownership");
        applyStimulus(1'b0, 4'b0010, 4'b0010);
        for (int c = 0; c < 3; c++) applyStimulus(1'b1, 4'b1111, 4'b0000);

        $display("[TB] random traffic");
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 3) == 0) randomizeOperands();
            applyStimulus(($urandom_range(0, 59) != 0),
                          NREQ'($urandom_range(0, 15)) | NREQ'($urandom_range(0, 15)),
                          NREQ'($urandom_range(0, 15)) | NREQ'($urandom_range(0, 15)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
